// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store stage over a req/ack word bus
// Accepts one access in IDLE, runs it on the bus with a timeout, then pulses resp_valid.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic [1:0]  fault,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] F_NONE  = 2'b00;
  localparam logic [1:0] F_ALIGN = 2'b01;
  localparam logic [1:0] F_ILL   = 2'b10;
  localparam logic [1:0] F_TMO   = 2'b11;

  state_t      state, state_nxt;
  logic [7:0]  tmo_cnt;
  logic        st_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  logic        req_illegal, req_misal, req_fault, tmo_hit;
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_data;

  // Request decode works on the live inputs; only used in the accept cycle.
  always_comb begin
    req_illegal = 1'b0;
    req_misal   = 1'b0;
    if (is_store)
      req_illegal = !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010);
    else
      req_illegal = (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
    case (funct3[1:0])
      2'b01:   req_misal = addr[0];
      2'b10:   req_misal = (addr[1:0] != 2'b00);
      default: req_misal = 1'b0;
    endcase
  end

  assign req_fault = req_illegal || req_misal;
  assign tmo_hit   = (tmo_cnt == TMO_LAST);

  always_comb begin
    st_strb = 4'b1111;
    st_data = wdata;
    case (funct3[1:0])
      2'b00: begin
        st_strb = 4'b0001 << addr[1:0];
        st_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        st_strb = 4'b0011 << addr[1:0];
        st_data = {2{wdata[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = wdata;
      end
    endcase
  end

  // Lane select and extension of the returned word using the latched request.
  always_comb begin
    case (off_q)
      2'd1:    lane_b = mem_rdata[15:8];
      2'd2:    lane_b = mem_rdata[23:16];
      2'd3:    lane_b = mem_rdata[31:24];
      default: lane_b = mem_rdata[7:0];
    endcase
    lane_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{lane_b[7]}}, lane_b};
      3'b100:  ld_data = {24'h0, lane_b};
      3'b001:  ld_data = {{16{lane_h[15]}}, lane_h};
      3'b101:  ld_data = {16'h0, lane_h};
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    busy       = 1'b1;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_nxt = req_fault ? RESP : BUSY;
      end
      BUSY: begin
        if (mem_ack || tmo_hit) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt   <= 8'h0;
      st_q      <= 1'b0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      rdata     <= 32'h0;
      fault     <= F_NONE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wstrb <= 4'h0;
      mem_wdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            st_q    <= is_store;
            f3_q    <= funct3;
            off_q   <= addr[1:0];
            tmo_cnt <= 8'h0;
            rdata   <= 32'h0;
            if (req_illegal) begin
              fault <= F_ILL;
            end else if (req_misal) begin
              fault <= F_ALIGN;
            end else begin
              fault     <= F_NONE;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wstrb <= is_store ? st_strb : 4'h0;
              mem_wdata <= is_store ? st_data : 32'h0;
            end
          end
        end
        BUSY: begin
          // An ack in the final timeout cycle still counts as a completion.
          if (mem_ack || tmo_hit) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wstrb <= 4'h0;
            mem_wdata <= 32'h0;
            fault     <= mem_ack ? F_NONE : F_TMO;
            rdata     <= (mem_ack && !st_q) ? ld_data : 32'h0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'h1;
          end
        end
        RESP: begin
          tmo_cnt <= 8'h0;
          rdata   <= 32'h0;
          fault   <= F_NONE;
        end
        default: tmo_cnt <= 8'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic [1:0]  fault;
  logic        busy, mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic        s_req, s_we, s_req_resp;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_strb;
  logic [1:0]  s_fault;
  int          resp_cyc, req_cnt;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .is_store(is_store), .funct3(funct3), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .rdata(rdata), .fault(fault), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request at cycle 0, ack at cycle ack_at (-1: never), record bus and response.
  task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] md, input int ack_at);
    req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd; mem_rdata = md;
    resp_cyc = -1; req_cnt = 0; s_rdata = 32'hX; s_fault = 2'bXX; s_req_resp = 1'bX;
    tick();
    req_valid = 1'b0; addr = 32'hDEAD_BEEF; funct3 = 3'b111; wdata = 32'hFFFF_FFFF;
    s_req = mem_req; s_we = mem_we; s_addr = mem_addr; s_strb = mem_wstrb; s_wdata = mem_wdata;
    for (int c = 1; c < 40; c++) begin
      if (resp_valid) begin
        resp_cyc = c; s_rdata = rdata; s_fault = fault; s_req_resp = mem_req;
        break;
      end
      if (mem_req) req_cnt++;
      mem_ack = (c == ack_at);
      tick();
      mem_ack = 1'b0;
    end
    tick();
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = 32'h0; wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;

    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_bus", {mem_we, mem_wstrb, mem_addr[3:0]}, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b1;
    tick();

    // LB with ack two cycles after mem_req
    access(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 3);
    chk("lb_mem_req", 32'(s_req), 32'd1);
    chk("lb_mem_addr", s_addr, 32'h0000_1000);
    chk("lb_mem_we", 32'(s_we), 32'd0);
    chk("lb_wstrb", 32'(s_strb), 32'h0);
    chk("lb_latency", resp_cyc, 32'd4);
    chk("lb_rdata", s_rdata, 32'hFFFF_FF80);
    chk("lb_fault", 32'(s_fault), 32'd0);
    chk("lb_req_dropped", 32'(s_req_resp), 32'd0);
    chk("lb_idle_after", 32'(req_ready), 32'd1);

    access(1'b0, 3'b100, 32'h0000_1003, 32'h0, 32'h80FF_1234, 3);
    chk("lbu_rdata", s_rdata, 32'h0000_0080);

    access(1'b0, 3'b001, 32'h0000_0100, 32'h0, 32'h1234_8001, 1);
    chk("lh_rdata", s_rdata, 32'hFFFF_8001);
    chk("lh_latency", resp_cyc, 32'd2);

    access(1'b0, 3'b010, 32'h0000_0104, 32'h0, 32'hA5A5_5A5A, 2);
    chk("lw_rdata", s_rdata, 32'hA5A5_5A5A);

    // SH with ack one cycle after mem_req
    access(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h5555_5555, 2);
    chk("sh_mem_we", 32'(s_we), 32'd1);
    chk("sh_mem_addr", s_addr, 32'h0000_2000);
    chk("sh_wstrb", 32'(s_strb), 32'hC);
    chk("sh_wdata", s_wdata, 32'hABCD_ABCD);
    chk("sh_rdata", s_rdata, 32'h0);
    chk("sh_latency", resp_cyc, 32'd3);

    // Faults never reach the bus
    access(1'b0, 3'b010, 32'h0000_3001, 32'h0, 32'h0, 1);
    chk("misal_req", 32'(s_req), 32'd0);
    chk("misal_reqcnt", req_cnt, 32'd0);
    chk("misal_latency", resp_cyc, 32'd1);
    chk("misal_fault", 32'(s_fault), 32'd1);
    chk("misal_rdata", s_rdata, 32'h0);

    access(1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 1);
    chk("ill_ld_fault", 32'(s_fault), 32'd2);
    chk("ill_ld_latency", resp_cyc, 32'd1);

    access(1'b1, 3'b100, 32'h0000_0100, 32'h0, 32'h0, 1);
    chk("ill_st_fault", 32'(s_fault), 32'd2);
    chk("ill_st_req", 32'(s_req), 32'd0);

    // Timeout with TIMEOUT_CYCLES=4, then a late ack in IDLE
    access(1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'h1111_1111, -1);
    chk("tmo_reqcnt", req_cnt, 32'd4);
    chk("tmo_latency", resp_cyc, 32'd5);
    chk("tmo_fault", 32'(s_fault), 32'd3);
    chk("tmo_rdata", s_rdata, 32'h0);
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("late_ack_busy", 32'(busy), 32'd0);
    chk("late_ack_resp", 32'(resp_valid), 32'd0);
    chk("late_ack_mem_req", 32'(mem_req), 32'd0);
    tick();
    chk("late_ack_ready", 32'(req_ready), 32'd1);

    // Ack on the cycle the timeout would fire wins
    access(1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'h7777_0001, 4);
    chk("race_fault", 32'(s_fault), 32'd0);
    chk("race_rdata", s_rdata, 32'h7777_0001);
    chk("race_latency", resp_cyc, 32'd5);

    // Reset asserted while BUSY
    req_valid = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0020;
    tick();
    req_valid = 1'b0;
    tick();
    chk("mid_pre_req", 32'(mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_async_req", 32'(mem_req), 32'd0);
    chk("mid_async_busy", 32'(busy), 32'd0);
    tick();
    chk("mid_no_resp", 32'(resp_valid), 32'd0);
    rst = 1'b1;
    tick();
    chk("mid_no_resp2", 32'(resp_valid), 32'd0);
    access(1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 1);
    chk("sw_wstrb", 32'(s_strb), 32'hF);
    chk("sw_wdata", s_wdata, 32'hCAFE_F00D);
    chk("sw_addr", s_addr, 32'h0000_0010);
    chk("sw_latency", resp_cyc, 32'd2);
    chk("sw_fault", 32'(s_fault), 32'd0);

    // Back-to-back: LHU then SB with req_valid held high
    req_valid = 1'b1; is_store = 1'b0; funct3 = 3'b101; addr = 32'h0000_0042;
    wdata = 32'h0; mem_rdata = 32'hBEEF_0000;
    tick();
    is_store = 1'b1; funct3 = 3'b000; addr = 32'h0000_0043; wdata = 32'h0000_00A5;
    chk("b2b_busy_ready", 32'(req_ready), 32'd0);
    chk("b2b_lhu_addr", mem_addr, 32'h0000_0040);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("b2b_lhu_resp", 32'(resp_valid), 32'd1);
    chk("b2b_lhu_rdata", rdata, 32'h0000_BEEF);
    chk("b2b_resp_ready", 32'(req_ready), 32'd0);
    tick();
    chk("b2b_idle_ready", 32'(req_ready), 32'd1);
    chk("b2b_idle_req", 32'(mem_req), 32'd0);
    tick();
    req_valid = 1'b0;
    chk("b2b_sb_req", 32'(mem_req), 32'd1);
    chk("b2b_sb_we", 32'(mem_we), 32'd1);
    chk("b2b_sb_wstrb", 32'(mem_wstrb), 32'h8);
    chk("b2b_sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    chk("b2b_sb_addr", mem_addr, 32'h0000_0040);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("b2b_sb_resp", 32'(resp_valid), 32'd1);
    chk("b2b_sb_rdata", rdata, 32'h0);
    chk("b2b_sb_fault", 32'(fault), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage that sits directly downstream of the ALU in the RV32I core.
- Takes the ALU result as the effective address and RS2 as store data.
- Runs one load or store over a word-wide request/acknowledge data-memory bus, then returns aligned, sign/zero-extended load data for regfile writeback.
- Holds `busy` high while an access is in flight, so the fetcher and decoder can stall.

Parameters:
- TIMEOUT_CYCLES, 16: cycles to wait in BUSY for `mem_ack` before declaring a timeout fault; legal range 1..255.

Ports:
- clk  input  1  core clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- req_valid  input  1  access request from the decode/execute stage
- req_ready  output  1  high only in IDLE; request accepted when `req_valid` && `req_ready`
- is_store  input  1  1 = store, 0 = load
- funct3  input  3  RV32I width/sign field
- addr  input  32  effective address (ALU `y`)
- wdata  input  32  store data (RS2)
- resp_valid  output  1  one-cycle completion pulse
- rdata  output  32  extended load data; 0 for stores and faults
- fault  output  2  00 none, 01 misaligned, 10 illegal funct3, 11 timeout; valid with `resp_valid`
- busy  output  1  high whenever state != IDLE
- mem_req  output  1  bus request, registered
- mem_we  output  1  bus write enable
- mem_addr  output  32  word address, {addr[31:2], 2'b00}
- mem_wstrb  output  4  byte write strobes; 0000 on loads
- mem_wdata  output  32  lane-replicated store data
- mem_ack  input  1  bus completion, single cycle
- mem_rdata  input  32  read word, sampled when `mem_ack` is high

Behaviour:
- Reset (async, rst=0): state=IDLE; all outputs 0 except `req_ready`=1. This includes `mem_req`, `resp_valid`, `fault`, `rdata`, `busy`, `mem_we`, `mem_addr`, `mem_wstrb` and `mem_wdata`. The timeout counter is 0.
- States: IDLE, BUSY, RESP.
- IDLE, on accept:
  - `is_store`, `funct3`, `addr` and `wdata` are latched.
  - Illegal `funct3` goes to RESP with `fault`=10:
    - loads: 011, 110, 111;
    - stores: any value other than 000, 001, 010.
  - Misaligned access goes to RESP with `fault`=01:
    - halfword with addr[0]=1;
    - word with addr[1:0]!=0.
  - Otherwise go to BUSY. `mem_req`, `mem_we`, `mem_addr`, `mem_wstrb` and `mem_wdata` become valid the next cycle.
  - Faulting requests never assert `mem_req`.
- BUSY:
  - `mem_req` and the bus fields are held stable until `mem_ack`.
  - When `mem_ack`=1: capture `mem_rdata`, drop `mem_req` next cycle, go to RESP with `fault`=00.
  - Each cycle without ack increments the counter. At counter==TIMEOUT_CYCLES-1 with no ack: drop `mem_req`, go to RESP with `fault`=11.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE; the counter is cleared. There is no backpressure on the response.
- Latency: accept at cycle 0, `mem_req` at cycle 1, ack at cycle k (k>=1), `resp_valid` at cycle k+1. A fault response is at cycle 1.
- Store strobes:
  - SB: 0001<<addr[1:0], `mem_wdata`={4{wdata[7:0]}}.
  - SH: 0011<<addr[1:0], `mem_wdata`={2{wdata[15:0]}}.
  - SW: 1111, `mem_wdata`=`wdata`.
- Loads: byte/half lane selected by the latched addr[1:0].
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- Boundaries:
  - `req_valid` while not IDLE is ignored (`req_ready`=0).
  - Input changes after accept have no effect.
  - `mem_ack` in IDLE or RESP is ignored, including a late ack after a timeout.
  - An ack on the same cycle the timeout would fire wins: completion with `fault`=00.
  - Back-to-back requests: a new accept is possible the cycle after RESP.
  - rst low mid-access: immediate return to IDLE, `mem_req` drops asynchronously, no `resp_valid` is produced.

Test Plan:
- LB, addr=0x1003, `mem_rdata`=0x80FF_1234, ack 2 cycles after `mem_req` -> `mem_addr`=0x1000, `resp_valid` 4 cycles after accept, `rdata`=0xFFFF_FF80, `fault`=00; LBU same stimulus -> `rdata`=0x0000_0080.
- SH, addr=0x2002, `wdata`=0x1234_ABCD, ack 1 cycle after `mem_req` -> `mem_we`=1, `mem_wstrb`=1100, `mem_wdata`=0xABCD_ABCD, `rdata`=0.
- LW, addr=0x3001 -> no `mem_req`, `resp_valid` at cycle 1, `fault`=01; load with `funct3`=011 -> `fault`=10.
- LW, TIMEOUT_CYCLES=4, `mem_ack` held 0 -> `mem_req` high for exactly 4 cycles, then `resp_valid` with `fault`=11; an ack 2 cycles later is ignored and the FSM stays in IDLE.
- Reset mid-access: rst=0 during BUSY -> `mem_req`=0 and `busy`=0 without waiting for clk, no `resp_valid`; after release, SW addr=0x10 completes normally with `mem_wstrb`=1111.
- Back-to-back: LHU addr=0x42 then SB addr=0x43, `req_valid` held high -> second accept the cycle after the first `resp_valid`; LHU with `mem_rdata`=0xBEEF_0000 gives `rdata`=0x0000_BEEF; the SB drives `mem_wstrb`=1000.
